// File: rtl/ahb_apb_splitter.sv
// AHB-Lite slave front end: splits each AHB transfer into APB-width beats over a req/done handshake.
// Optional define AHB_BRIDGE_ALIGN_CHECK_EN: oversize or misaligned transfers get an ERROR response.
module ahb_apb_splitter #(
    parameter int AHB_AW = 32,
    parameter int AHB_DW = 32,
    parameter int APB_DW = 8
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              i_HSEL,
    input  logic [AHB_AW-1:0] i_HADDR,
    input  logic [1:0]        i_HTRANS,
    input  logic              i_HWRITE,
    input  logic [2:0]        i_HSIZE,
    input  logic [AHB_DW-1:0] i_HWDATA,
    input  logic              i_HREADY,
    output logic              o_HREADYOUT,
    output logic              o_HRESP,
    output logic [AHB_DW-1:0] o_HRDATA,
    output logic              o_req,
    output logic              o_req_write,
    output logic [AHB_AW-1:0] o_req_addr,
    output logic [APB_DW-1:0] o_req_wdata,
    input  logic              i_req_done,
    input  logic [APB_DW-1:0] i_req_rdata,
    input  logic              i_req_err
);
    localparam int AHB_BYTES = AHB_DW / 8;
    localparam int APB_BYTES = APB_DW / 8;
    localparam int LANES     = AHB_DW / APB_DW;
    localparam int LOG_AHB   = $clog2(AHB_BYTES);
    localparam int LOG_APB   = $clog2(APB_BYTES);
    localparam int CW        = $clog2(LANES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CAPT, S_BEAT, S_LAST, S_ERR1, S_ERR2
    } state_t;

    state_t              state_q, state_d;
    logic [AHB_AW-1:0]   addr_q;
    logic                write_q;
    logic [2:0]          size_q;
    logic                bad_q;
    logic [AHB_DW-1:0]   wdata_q;
    logic [AHB_DW-1:0]   rdata_q;
    logic [CW-1:0]       cnt_q;

    logic                accept;
    logic [2:0]          size_clamp;
    logic                bad;
    logic [CW-1:0]       last_cnt;
    logic [AHB_AW-1:0]   beat_addr;
    logic [LOG_AHB-1:0]  lane;
`ifdef AHB_BRIDGE_ALIGN_CHECK_EN
    logic [AHB_AW-1:0]   align_mask;
`endif
    logic                unused_htrans0;

    assign unused_htrans0 = i_HTRANS[0];

    always_comb begin
        state_d     = state_q;
        o_HREADYOUT = 1'b0;
        o_HRESP     = 1'b0;
        o_req       = 1'b0;
        o_req_wdata = '0;

        accept = i_HSEL & i_HREADY & i_HTRANS[1] &
                 ((state_q == S_IDLE) | (state_q == S_LAST) | (state_q == S_ERR2));
        size_clamp = (i_HSIZE > 3'(LOG_AHB)) ? 3'(LOG_AHB) : i_HSIZE;
`ifdef AHB_BRIDGE_ALIGN_CHECK_EN
        align_mask = (AHB_AW'(1) << i_HSIZE) - AHB_AW'(1);
        bad = (i_HSIZE > 3'(LOG_AHB)) | (|(i_HADDR & align_mask));
`else
        bad = 1'b0;
`endif
        // Transfers no wider than one APB beat still take a single beat.
        last_cnt  = (size_q > 3'(LOG_APB)) ? CW'((1 << (size_q - 3'(LOG_APB))) - 1) : '0;
        beat_addr = addr_q + (AHB_AW'(cnt_q) << LOG_APB);
        lane      = beat_addr[LOG_AHB-1:0] >> LOG_APB;

        for (int unsigned l = 0; l < LANES; l++) begin
            if (lane == LOG_AHB'(l)) o_req_wdata = wdata_q[l*APB_DW +: APB_DW];
        end

        unique case (state_q)
            S_IDLE: begin
                o_HREADYOUT = 1'b1;
                if (accept) state_d = S_CAPT;
            end
            S_CAPT: state_d = bad_q ? S_ERR1 : S_BEAT;
            S_BEAT: begin
                o_req = 1'b1;
                if (i_req_done) begin
                    if (i_req_err)              state_d = S_ERR1;
                    else if (cnt_q == last_cnt) state_d = S_LAST;
                end
            end
            S_LAST: begin
                o_HREADYOUT = 1'b1;
                state_d     = accept ? S_CAPT : S_IDLE;
            end
            S_ERR1: begin
                o_HRESP = 1'b1;
                state_d = S_ERR2;
            end
            S_ERR2: begin
                o_HREADYOUT = 1'b1;
                o_HRESP     = 1'b1;
                state_d     = accept ? S_CAPT : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_req_write = write_q;
    assign o_req_addr  = beat_addr;
    assign o_HRDATA    = rdata_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
            bad_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= i_HADDR;
                write_q <= i_HWRITE;
                size_q  <= size_clamp;
                bad_q   <= bad;
                if (!i_HWRITE) rdata_q <= '0;
            end
            if (state_q == S_CAPT) begin
                wdata_q <= i_HWDATA;
                cnt_q   <= '0;
            end
            if ((state_q == S_BEAT) && i_req_done && !i_req_err) begin
                if (!write_q) begin
                    for (int unsigned l = 0; l < LANES; l++) begin
                        if (lane == LOG_AHB'(l)) rdata_q[l*APB_DW +: APB_DW] <= i_req_rdata;
                    end
                end
                if (cnt_q != last_cnt) cnt_q <= cnt_q + CW'(1);
            end
        end
    end
endmodule
